// File: rtl/sha256_arb_pkg.sv
// Shared definitions for the sha256crypt word-stage arbiter:
// state encoding, source-index width and the round-robin successor helper.
package sha256_arb_pkg;

  // Width of a requester index (supports up to 8 requesters).
  localparam int SRC_W   = 3;
  // Upper bound on requesters; per-requester vectors are padded to this size
  // so that a SRC_W-bit index always addresses a legal element.
  localparam int MAX_REQ = 8;
  // Beat counter width; bursts are limited to 15 words.
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  // Successor of idx in a ring of n requesters (wraps n-1 back to 0).
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx,
                                               input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      rr_next = '0;
    end else begin
      rr_next = idx + 1'b1;
    end
  endfunction

endpackage

// File: rtl/ff16_rr_pick.sv
// Combinational round-robin pick: returns the first set request bit found
// scanning ptr+1, ptr+2, ... with wrap-around over N_REQ requesters.
// The requester at ptr itself is considered last.
module ff16_rr_pick
  import sha256_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             any,
  output logic [SRC_W-1:0] idx
);

  logic [MAX_REQ-1:0] req_pad;
  logic [SRC_W-1:0]   cand;

  // Walk the ring once starting after ptr and keep the first hit.
  always_comb begin
    req_pad            = '0;
    req_pad[N_REQ-1:0] = req;
    any                = 1'b0;
    idx                = '0;
    cand               = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_next(cand, N_REQ);
      if (!any && req_pad[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/ff16_rr_arbiter.sv
// Round-robin burst arbiter sharing one 16-bit enable/clear register stage
// between N_REQ word producers ahead of the SHA-256 message schedule.
// A grant passes up to BURST words (one per cycle) with a registered enable
// strobe; a packet end is followed by a one-cycle registered clear strobe.
// Optional per-requester word statistics are built when the macro
// FF16_ARB_STATS_EN is defined; otherwise stat_cnt reads 0.
module ff16_rr_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N     = 16,
  parameter int BURST = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*N-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               out_ready,
  output logic               o_en,
  output logic               o_clr,
  output logic [N-1:0]       o_data,
  output logic [SRC_W-1:0]   o_src,
  output logic               o_last,
  input  logic [SRC_W-1:0]   stat_sel,
  output logic [15:0]        stat_cnt
);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

  // Arbitration state.
  arb_state_t         state_reg;
  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   grant_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Registered outputs toward the shared register stage.
  logic               o_en_reg;
  logic               o_clr_reg;
  logic [N-1:0]       o_data_reg;
  logic [SRC_W-1:0]   o_src_reg;
  logic               o_last_reg;

  // Requester views padded to MAX_REQ so any SRC_W-bit index is in range.
  logic [MAX_REQ-1:0] valid_pad;
  logic [MAX_REQ-1:0] last_pad;
  logic [N-1:0]       data_arr [MAX_REQ];
  logic [MAX_REQ-1:0] ready_pad;

  logic               pick_any;
  logic [SRC_W-1:0]   pick_idx;

  logic               cur_valid;
  logic               cur_last;
  logic [N-1:0]       cur_data;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
      if (gi < N_REQ) begin : g_live
        assign valid_pad[gi] = req_valid[gi];
        assign last_pad[gi]  = req_last[gi];
        assign data_arr[gi]  = req_data[gi*N +: N];
      end else begin : g_absent
        assign valid_pad[gi] = 1'b0;
        assign last_pad[gi]  = 1'b0;
        assign data_arr[gi]  = '0;
      end
    end
  endgenerate

  ff16_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign cur_valid = valid_pad[grant_reg];
  assign cur_last  = last_pad[grant_reg];
  assign cur_data  = data_arr[grant_reg];
  assign xfer      = (state_reg == GRANT) && cur_valid && out_ready;
  assign cnt_next  = cnt_reg + 1'b1;

  // Only the granted requester sees downstream readiness, and only in GRANT.
  always_comb begin
    ready_pad = '0;
    if (state_reg == GRANT) begin
      ready_pad[grant_reg] = out_ready;
    end
  end

  assign req_ready = ready_pad[N_REQ-1:0];

  // Arbitration FSM with registered enable/clear/data outputs.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= SRC_W'(N_REQ - 1);
      grant_reg  <= '0;
      cnt_reg    <= '0;
      o_en_reg   <= 1'b0;
      o_clr_reg  <= 1'b0;
      o_data_reg <= '0;
      o_src_reg  <= '0;
      o_last_reg <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_en_reg  <= 1'b0;
      o_clr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg  <= pick_idx;
            rr_ptr_reg <= pick_idx;
            cnt_reg    <= '0;
            state_reg  <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            o_en_reg   <= 1'b1;
            o_data_reg <= cur_data;
            o_src_reg  <= grant_reg;
            o_last_reg <= cur_last;
            cnt_reg    <= cnt_next;
            // Packet end takes priority over the burst limit.
            if (cur_last) begin
              state_reg <= FLUSH;
            end else if (cnt_next == BURST_CNT) begin
              state_reg <= IDLE;
            end
          end else if ((cnt_reg == '0) && !cur_valid) begin
            // Requester withdrew before its first word: release the grant.
            state_reg <= IDLE;
          end
        end
        FLUSH: begin
          o_clr_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_en   = o_en_reg;
  assign o_clr  = o_clr_reg;
  assign o_data = o_data_reg;
  assign o_src  = o_src_reg;
  assign o_last = o_last_reg;

`ifdef FF16_ARB_STATS_EN
  logic [15:0] stat_arr [MAX_REQ];
  logic [15:0] stat_cnt_reg;

  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_stat
      if (gi < N_REQ) begin : g_live
        logic [15:0] word_cnt_reg;
        // Saturating count of words transferred by this requester.
        always_ff @(posedge CLK or posedge rst) begin
          if (rst) begin
            word_cnt_reg <= '0;
          end else if (xfer && (grant_reg == SRC_W'(gi)) &&
                       (word_cnt_reg != 16'hFFFF)) begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
          end
        end
        assign stat_arr[gi] = word_cnt_reg;
      end else begin : g_absent
        assign stat_arr[gi] = '0;
      end
    end
  endgenerate

  // Registered statistics read; selects beyond N_REQ read as zero.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stat_cnt_reg <= '0;
    end else if (32'(stat_sel) < N_REQ) begin
      stat_cnt_reg <= stat_arr[stat_sel];
    end else begin
      stat_cnt_reg <= '0;
    end
  end

  assign stat_cnt = stat_cnt_reg;
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_ff16_rr_arbiter.sv
// Self-checking bench for ff16_rr_arbiter: a behavioural owner/beat model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ff16_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int BURST = 4;

  logic              CLK = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_ready;
  logic              o_en;
  logic              o_clr;
  logic [W-1:0]      o_data;
  logic [2:0]        o_src;
  logic              o_last;
  logic [2:0]        stat_sel;
  logic [15:0]       stat_cnt;

  ff16_rr_arbiter #(.N_REQ(NREQ), .N(W), .BURST(BURST)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_ready (out_ready),
    .o_en      (o_en),
    .o_clr     (o_clr),
    .o_data    (o_data),
    .o_src     (o_src),
    .o_last    (o_last),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_owner = -1 means nobody holds the stage; m_closing marks the packet
  // end turnaround cycle that must produce a clear strobe next.
  int          m_owner;
  int          m_beats;
  int          m_ptr;
  bit          m_closing;
  logic        m_en, m_clr, m_last;
  logic [15:0] m_data;
  logic [2:0]  m_src;
  logic [15:0] m_stat [8];
  logic [15:0] m_stat_out;

  function automatic int first_after(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready(input int owner, input logic rdy);
    logic [NREQ-1:0] r;
    r = '0;
    if (owner >= 0) r[owner] = rdy;
    return r;
  endfunction

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_beats <= 0; m_ptr <= NREQ - 1; m_closing <= 1'b0;
      m_en <= 1'b0; m_clr <= 1'b0; m_last <= 1'b0; m_data <= '0; m_src <= '0;
      m_stat_out <= '0;
      for (int i = 0; i < 8; i++) m_stat[i] <= '0;
    end else begin
      m_en  <= 1'b0;
      m_clr <= 1'b0;
      m_stat_out <= (int'(stat_sel) < NREQ) ? m_stat[stat_sel] : 16'h0;
      if (m_closing) begin
        m_clr     <= 1'b1;
        m_closing <= 1'b0;
      end else if (m_owner < 0) begin
        if (first_after(m_ptr, req_valid) >= 0) begin
          m_owner <= first_after(m_ptr, req_valid);
          m_ptr   <= first_after(m_ptr, req_valid);
          m_beats <= 0;
        end
      end else if (req_valid[m_owner] && out_ready) begin
        m_en   <= 1'b1;
        m_data <= req_data[m_owner*W +: W];
        m_src  <= 3'(m_owner);
        m_last <= req_last[m_owner];
        m_beats <= m_beats + 1;
        if (m_stat[m_owner] != 16'hFFFF) m_stat[m_owner] <= m_stat[m_owner] + 16'd1;
        if (req_last[m_owner]) begin
          m_owner   <= -1;
          m_closing <= 1'b1;
        end else if (m_beats + 1 == BURST) begin
          m_owner <= -1;
        end
      end else if (m_beats == 0 && !req_valid[m_owner]) begin
        m_owner <= -1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (cmp_on && !rst) begin
      chk("o_en", o_en, m_en);
      chk("o_clr", o_clr, m_clr);
      chk("o_data", o_data, m_data);
      chk("o_src", o_src, m_src);
      chk("o_last", o_last, m_last);
      chk("req_ready", req_ready, exp_ready(m_owner, out_ready));
`ifdef FF16_ARB_STATS_EN
      chk("stat_cnt", stat_cnt, m_stat_out);
`else
      chk("stat_cnt", stat_cnt, 16'h0);
`endif
      chk("en_clr_exclusive", o_en & o_clr, 1'b0);
    end
  end

  // Event log of enable/clear strobes for directed checks.
  int          ev_cyc[$];
  int          ev_src[$];
  logic [15:0] ev_data[$];
  logic        ev_last[$];
  int          clr_cyc[$];

  always @(negedge CLK) begin
    if (!rst) begin
      if (o_en) begin
        ev_cyc.push_back(cyc);
        ev_src.push_back(int'(o_src));
        ev_data.push_back(o_data);
        ev_last.push_back(o_last);
      end
      if (o_clr) clr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    ev_cyc.delete(); ev_src.delete(); ev_data.delete(); ev_last.delete(); clr_cyc.delete();
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1; stat_sel = '0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;
    rst = 1'b0;
    clear_log();
  endtask

  // Offer n words from requester r; accepted when req_ready is seen high.
  task automatic send(input int r, input int n, input logic [15:0] base,
                      input bit last_end, input bit toggle_rdy, input int max_cyc);
    int  sent;
    int  k;
    bit  phase;
    logic acc;
    sent = 0; k = 0; phase = 1'b1;
    while (sent < n && k < max_cyc) begin
      req_valid[r] = 1'b1;
      req_data[r*W +: W] = base + 16'(sent);
      req_last[r] = last_end && (sent == n - 1);
      if (toggle_rdy) out_ready = phase;
      @(negedge CLK);
      acc = req_ready[r];
      @(posedge CLK); #1;
      if (acc) sent++;
      phase = !phase;
      k++;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
    out_ready    = 1'b1;
    if (sent < n) chk("send_timeout", sent, n);
  endtask

  int exp_src[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
  int n_ev;

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2 rst = 1'b1;
    // Reset state with requests and readiness present.
    req_valid = 4'hF;
    @(negedge CLK);
    chk("rst_o_en", o_en, 1'b0);
    chk("rst_o_clr", o_clr, 1'b0);
    chk("rst_o_data", o_data, 16'h0);
    chk("rst_o_src", o_src, 3'd0);
    chk("rst_o_last", o_last, 1'b0);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_stat_cnt", stat_cnt, 16'h0);
    req_valid = '0;
    @(posedge CLK); #1;
    rst = 1'b0;
    cmp_on = 1'b1;
    clear_log();

    // Fairness: all requesters valid, no packet ends.
    req_valid = 4'hF;
    req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    repeat (23) @(posedge CLK);
    #1;
    n_ev = ev_src.size();
    chk("fair_count_ge17", 32'(n_ev >= 17), 1);
    if (n_ev >= 17) begin
      for (int i = 0; i < 17; i++) chk($sformatf("fair_src%0d", i), ev_src[i], exp_src[i]);
      chk("fair_b2b_gap", ev_cyc[1] - ev_cyc[0], 1);
      chk("fair_idle_gap", ev_cyc[4] - ev_cyc[3], 2);
      chk("fair_data4", ev_data[4], 16'hD001);
    end
    do_reset();

    // Packet end from requester 2.
    send(2, 3, 16'hA001, 1'b1, 1'b0, 30);
    repeat (4) @(posedge CLK);
    #1;
    chk("pkt_count", ev_src.size(), 3);
    chk("pkt_clr_count", clr_cyc.size(), 1);
    if (ev_src.size() == 3 && clr_cyc.size() == 1) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("pkt_data%0d", i), ev_data[i], 16'hA001 + 16'(i));
        chk($sformatf("pkt_src%0d", i), ev_src[i], 2);
        chk($sformatf("pkt_last%0d", i), ev_last[i], (i == 2) ? 1'b1 : 1'b0);
      end
      chk("pkt_clr_after_last", clr_cyc[0] - ev_cyc[2], 1);
    end
    do_reset();

    // Backpressure on requester 1: out_ready alternates 1,0,1,0.
    send(1, 4, 16'hB001, 1'b0, 1'b1, 40);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_count", ev_src.size(), 4);
    if (ev_src.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("bp_data%0d", i), ev_data[i], 16'hB001 + 16'(i));
        chk($sformatf("bp_src%0d", i), ev_src[i], 1);
        if (i > 0) chk($sformatf("bp_gap%0d", i), ev_cyc[i] - ev_cyc[i-1], 2);
      end
    end
    do_reset();

    // Pre-lock release: requester 3 granted, withdraws before its first word.
    req_valid = 4'b1000;
    out_ready = 1'b0;
    @(posedge CLK); #1;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("prelock_ready_g3", req_ready, 4'b1000);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("prelock_ready_idle", req_ready, 4'b0000);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("prelock_ready_g0", req_ready, 4'b0001);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("prelock_en", o_en, 1'b1);
    chk("prelock_src", o_src, 3'd0);
    req_valid = '0;
    do_reset();

    // Reset in the middle of a burst.
    req_valid = 4'b0011;
    req_data  = {16'h0, 16'h0, 16'hC101, 16'hC001};
    repeat (3) @(posedge CLK);
    #3 rst = 1'b1;
    @(negedge CLK);
    chk("midrst_o_en", o_en, 1'b0);
    chk("midrst_o_data", o_data, 16'h0);
    chk("midrst_o_src", o_src, 3'd0);
    chk("midrst_o_last", o_last, 1'b0);
    chk("midrst_o_clr", o_clr, 1'b0);
    chk("midrst_req_ready", req_ready, 4'h0);
    @(posedge CLK); #1;
    rst = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("midrst_first_en", o_en, 1'b1);
    chk("midrst_first_src", o_src, 3'd0);
    chk("midrst_first_data", o_data, 16'hC001);
    @(posedge CLK); #1;
    req_valid = '0;
    do_reset();

    // Statistics: requester 1 moves 10 words.
    send(1, 10, 16'hE000, 1'b0, 1'b0, 60);
    stat_sel = 3'd1;
    @(posedge CLK);
    @(negedge CLK);
`ifdef FF16_ARB_STATS_EN
    chk("stat_req1", stat_cnt, 16'd10);
`else
    chk("stat_req1", stat_cnt, 16'd0);
`endif
    #1 stat_sel = 3'd5;
    @(posedge CLK);
    @(negedge CLK);
    chk("stat_sel_oob", stat_cnt, 16'd0);
    #1 stat_sel = 3'd0;
    @(posedge CLK);
    @(negedge CLK);
    chk("stat_req0", stat_cnt, 16'd0);

    repeat (2) @(posedge CLK);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ff16_rr_arbiter.md
Name: ff16_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream 16-bit enable/clear register stage (one word register per core slot) between N_REQ word producers in the sha256crypt core.
- Sequences bursts: grants one producer, passes up to BURST words with a registered enable strobe, then issues a one-cycle clear at packet end and rotates to the next producer.
- Sits between the key/salt word sources and the shared register stage feeding the SHA-256 message schedule.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N, 16, word width.
- BURST, 4, maximum words per grant before forced rotation (1..15).

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*N  per-requester word; requester k uses bits [k*N +: N].
- req_last  in  N_REQ  word is the last of the requester's packet.
- req_ready  out  N_REQ  per-requester accept; combinational.
- out_ready  in  1  downstream can take a word this cycle.
- o_en  out  1  registered enable strobe to the shared register.
- o_clr  out  1  registered clear strobe to the shared register.
- o_data  out  N  registered word.
- o_src  out  3  registered index of the source of o_data.
- o_last  out  1  registered copy of req_last for the transferred word.
- stat_sel  in  3  statistics requester select.
- stat_cnt  out  16  statistics word count for stat_sel.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=N_REQ-1, grant=0, beat count=0. o_en, o_clr, o_data, o_src and o_last are all 0. req_ready=0. Counters are 0.
- IDLE:
  - If any req_valid is set, pick the first set index scanning rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - Latch it in grant, set rr_ptr=grant, cnt=0, go to GRANT.
  - Decision is 1 cycle; no transfer happens in IDLE.
- GRANT:
  - req_ready[grant] = out_ready. All other req_ready bits are 0.
  - Transfer when req_valid[grant] && req_ready[grant]. Next cycle: o_en=1, o_data=req_data[grant], o_src=grant, o_last=req_last[grant]. Otherwise o_en=0 and o_data/o_src/o_last hold.
  - Beat count increments on each transfer.
  - Transfer with req_last=1: go to FLUSH.
  - Transfer that makes cnt==BURST without last: go to IDLE (rotation; packet resumes at a later grant).
  - cnt==0 and req_valid[grant]==0: return to IDLE (no lock before the first word).
  - cnt>0 and req_valid[grant] low: stay in GRANT (burst locked).
- FLUSH:
  - o_clr=1 on the cycle after entry, for exactly one cycle; no transfers; next state IDLE.
  - o_en and o_clr are never high together.
- Latency: handshake to o_en is 1 cycle. Back-to-back words in GRANT give 1 word/cycle.
- out_ready low stalls GRANT without changing state or cnt.
- Simultaneous req_last and cnt reaching BURST: req_last wins (FLUSH).
- With a single active requester, it is re-granted after each IDLE cycle. Throughput is BURST words per BURST+1 cycles, or +2 cycles when the burst ends with a packet end.
- An index outside 0..N_REQ-1 is never granted; stat_sel ≥ N_REQ reads 0.

Optional Feature:
- Macro: FF16_ARB_STATS_EN.
- Defined: one 16-bit word counter per requester, incremented on each of its transfers, saturating at 16'hFFFF. stat_cnt = counter[stat_sel], registered with 1-cycle latency. Counters are cleared by rst only.
- Undefined: no counters are built; stat_cnt is tied to 0; ports are unchanged.

Decomposition:
- Shared package sha256_arb_pkg: state encoding (IDLE=2'd0, GRANT=2'd1, FLUSH=2'd2), SRC_W=3 constant, function for round-robin next index.
- One sub-module: ff16_rr_pick, a combinational priority pick of the first set bit of a request vector starting after rr_ptr, with wrap-around.

Test Plan:
- Reset mid-GRANT: assert rst during a burst → next edge gives all outputs 0, state IDLE, rr_ptr=3. A subsequent request from requester 0 alone is granted first.
- Fairness: all 4 requesters continuously valid, no last, BURST=4 → o_src sequence 0,0,0,0,1,1,1,1,2,…,3,0. Exactly one idle cycle between bursts.
- Packet end: requester 2 sends 3 words (3rd with last), data 16'hA001..16'hA003 → three o_en pulses with those data and o_src=2, o_last on the 3rd, then o_clr one cycle later, then IDLE.
- Backpressure: out_ready toggled 1,0,1,0 during a burst from requester 1 → o_en only after ready-high cycles, with no lost or duplicated words and count unaffected by stalls.
- Pre-lock release: requester 3 granted, drops valid before any transfer while requester 0 is valid → return to IDLE, and requester 0 is granted next.
- Stats (FF16_ARB_STATS_EN): requester 1 transfers 10 words, stat_sel=1 → stat_cnt=10 one cycle later. With the macro undefined, stat_cnt=0.
